// File: rtl/spi_master_apb_regs_if.sv
// APB3 completer-side bus bundle for the SPI master register block.
// The master drives address/control, the slave returns data/ready/error.
interface spi_master_apb_regs_if #(
  parameter int AW = 12
);
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA;
  logic          PREADY;
  logic          PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/spi_master_apb_regs.sv
// APB register front-end for the SPI master: config regs, FIFO
// access with wait states and timeout, busy lock and interrupts.
module spi_master_apb_regs #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_CS         = 4,
  parameter int CLKDIV_W       = 8,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  spi_master_apb_regs_if.slave apb,
  input  logic [31:0]         spi_status,
  output logic [CLKDIV_W-1:0] spi_clk_div,
  output logic                spi_clk_div_valid,
  output logic [31:0]         spi_cmd,
  output logic [31:0]         spi_addr,
  output logic [5:0]          spi_cmd_len,
  output logic [5:0]          spi_addr_len,
  output logic [15:0]         spi_data_len,
  output logic [15:0]         spi_dummy_rd,
  output logic [15:0]         spi_dummy_wr,
  output logic [NUM_CS-1:0]   spi_csreg,
  output logic                spi_rd,
  output logic                spi_wr,
  output logic                spi_qrd,
  output logic                spi_qwr,
  output logic                spi_swrst,
  output logic [31:0]         spi_data_tx,
  output logic                spi_data_tx_valid,
  input  logic                spi_data_tx_ready,
  input  logic [31:0]         spi_data_rx,
  input  logic                spi_data_rx_valid,
  output logic                spi_data_rx_ready,
  output logic                irq
);

  localparam logic [3:0] A_STATUS  = 4'd0;
  localparam logic [3:0] A_CMD     = 4'd1;
  localparam logic [3:0] A_CLKDIV  = 4'd2;
  localparam logic [3:0] A_SPICMD  = 4'd3;
  localparam logic [3:0] A_SPIADR  = 4'd4;
  localparam logic [3:0] A_SPILEN  = 4'd5;
  localparam logic [3:0] A_SPIDUM  = 4'd6;
  localparam logic [3:0] A_TXFIFO  = 4'd7;
  localparam logic [3:0] A_RXFIFO  = 4'd8;
  localparam logic [3:0] A_IRQEN   = 4'd9;
  localparam logic [3:0] A_IRQPEND = 4'd10;

  localparam int WCW =
    (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WCW-1:0] TMO_LAST =
    WCW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  state_e               state_q;
  logic [WCW-1:0]       wcnt_q;

  logic [CLKDIV_W-1:0]  clk_div_q;
  logic                 div_vld_q;
  logic [31:0]          cmd_q;
  logic [31:0]          adr_q;
  logic [5:0]           cmd_len_q;
  logic [5:0]           adr_len_q;
  logic [15:0]          data_len_q;
  logic [15:0]          dum_rd_q;
  logic [15:0]          dum_wr_q;
  logic [NUM_CS-1:0]    cs_q;
  logic [4:0]           pulse_q;
  logic [1:0]           irq_en_q;
  logic [1:0]           pend_q;
  logic [1:0]           pend_d;
  logic                 busy_q;
  logic                 irq_q;

  logic [3:0]  addr;
  logic [15:0] sel;
  logic        access;
  logic        wr;
  logic        busy;
  logic        mapped;
  logic        is_ro;
  logic        is_wo;
  logic        locked;
  logic        acc_err;
  logic        tx_acc;
  logic        rx_acc;
  logic        fifo_acc;
  logic        fifo_rdy;
  logic        tmo;
  logic        pready;
  logic        wr_ok;
  logic        rd_ok;
  logic [1:0]  pend_set;
  logic [1:0]  pend_clr;
  logic [31:0] rdata;
  logic        unused_paddr;

  assign addr   = apb.PADDR[5:2];
  assign sel    = 16'b1 << addr;
  assign access = apb.PSEL & apb.PENABLE;
  assign wr     = apb.PWRITE;
  assign busy   = spi_status[0];

  assign mapped = ~|sel[15:11];
  assign is_ro  = sel[A_STATUS] | sel[A_RXFIFO];
  assign is_wo  = sel[A_CMD] | sel[A_TXFIFO];

  // swrst alone is never locked so a hung controller can be recovered
  assign locked = busy & wr &
                  (sel[A_CLKDIV] | sel[A_SPICMD] | sel[A_SPIADR] |
                   sel[A_SPILEN] | sel[A_SPIDUM] |
                   (sel[A_CMD] & |apb.PWDATA[3:0]));

  assign acc_err = ~mapped | (wr & is_ro) | (~wr & is_wo) | locked;

  assign tx_acc   = access & wr & sel[A_TXFIFO];
  assign rx_acc   = access & ~wr & sel[A_RXFIFO];
  assign fifo_acc = tx_acc | rx_acc;
  assign fifo_rdy = tx_acc ? spi_data_tx_ready : spi_data_rx_valid;

  assign tmo = (TIMEOUT_CYCLES != 0) & fifo_acc & ~fifo_rdy &
               (wcnt_q == TMO_LAST);

  assign pready = ~fifo_acc | fifo_rdy | tmo;
  assign wr_ok  = access & wr & ~acc_err & ~fifo_acc;
  assign rd_ok  = access & ~wr & ~acc_err;

  always_comb begin
    rdata = '0;
    if (rd_ok) begin
      unique case (1'b1)
        sel[A_STATUS]:  rdata = spi_status;
        sel[A_CLKDIV]:  rdata = 32'(clk_div_q);
        sel[A_SPICMD]:  rdata = cmd_q;
        sel[A_SPIADR]:  rdata = adr_q;
        sel[A_SPILEN]:  rdata = {data_len_q, 2'b0, adr_len_q,
                                 2'b0, cmd_len_q};
        sel[A_SPIDUM]:  rdata = {dum_wr_q, dum_rd_q};
        sel[A_RXFIFO]:  rdata = spi_data_rx_valid ? spi_data_rx : '0;
        sel[A_IRQEN]:   rdata = {30'b0, irq_en_q};
        sel[A_IRQPEND]: rdata = {30'b0, pend_q};
        default:        rdata = '0;
      endcase
    end
  end

  // bus-facing strobes are cut by reset so an aborted access has no effect
  assign apb.PRDATA  = HRESETn ? rdata : '0;
  assign apb.PREADY  = HRESETn & pready;
  assign apb.PSLVERR = HRESETn & access & (acc_err | tmo);

  assign spi_data_tx       = apb.PWDATA;
  assign spi_data_tx_valid = HRESETn & tx_acc & ~tmo;
  assign spi_data_rx_ready = HRESETn & rx_acc & spi_data_rx_valid & ~tmo;

  assign pend_set = {access & tmo, busy_q & ~busy};
  assign pend_clr = (wr_ok & sel[A_IRQPEND]) ? apb.PWDATA[1:0] : 2'b0;
  assign pend_d   = (pend_q & ~pend_clr) | pend_set;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (fifo_acc & ~pready) begin
            state_q <= WAIT;
            wcnt_q  <= wcnt_q + 1'b1;
          end else begin
            wcnt_q  <= '0;
          end
        end
        WAIT: begin
          if (~fifo_acc | pready) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
          end else begin
            wcnt_q  <= wcnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          wcnt_q  <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      clk_div_q  <= '0;
      div_vld_q  <= 1'b0;
      cmd_q      <= '0;
      adr_q      <= '0;
      cmd_len_q  <= '0;
      adr_len_q  <= '0;
      data_len_q <= '0;
      dum_rd_q   <= '0;
      dum_wr_q   <= '0;
      cs_q       <= '0;
      pulse_q    <= '0;
      irq_en_q   <= '0;
      pend_q     <= '0;
      busy_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pulse_q   <= '0;
      div_vld_q <= 1'b0;
      busy_q    <= busy;
      pend_q    <= pend_d;
      irq_q     <= |(pend_q & irq_en_q);
      if (wr_ok) begin
        unique case (1'b1)
          sel[A_CMD]: begin
            pulse_q <= apb.PWDATA[4:0];
            cs_q    <= apb.PWDATA[8 +: NUM_CS];
          end
          sel[A_CLKDIV]: begin
            clk_div_q <= apb.PWDATA[CLKDIV_W-1:0];
            div_vld_q <= 1'b1;
          end
          sel[A_SPICMD]: cmd_q <= apb.PWDATA;
          sel[A_SPIADR]: adr_q <= apb.PWDATA;
          sel[A_SPILEN]: begin
            cmd_len_q  <= apb.PWDATA[5:0];
            adr_len_q  <= apb.PWDATA[13:8];
            data_len_q <= apb.PWDATA[31:16];
          end
          sel[A_SPIDUM]: begin
            dum_rd_q <= apb.PWDATA[15:0];
            dum_wr_q <= apb.PWDATA[31:16];
          end
          sel[A_IRQEN]: irq_en_q <= apb.PWDATA[1:0];
          default: ;
        endcase
      end
    end
  end

  assign spi_clk_div       = clk_div_q;
  assign spi_clk_div_valid = div_vld_q;
  assign spi_cmd           = cmd_q;
  assign spi_addr          = adr_q;
  assign spi_cmd_len       = cmd_len_q;
  assign spi_addr_len      = adr_len_q;
  assign spi_data_len      = data_len_q;
  assign spi_dummy_rd      = dum_rd_q;
  assign spi_dummy_wr      = dum_wr_q;
  assign spi_csreg         = cs_q;
  assign {spi_swrst, spi_qwr, spi_qrd, spi_wr, spi_rd} = pulse_q;
  assign irq               = irq_q;

  assign unused_paddr = ^{apb.PADDR[APB_ADDR_WIDTH-1:6], apb.PADDR[1:0]};

endmodule

// File: tb/tb_spi_master_apb_regs.sv
// Scoreboard bench for the SPI master APB register block.
// Expected read data is queued at stimulus time and popped at completion.
module tb_spi_master_apb_regs;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] spi_status;
  logic [7:0]  spi_clk_div;
  logic        spi_clk_div_valid;
  logic [31:0] spi_cmd;
  logic [31:0] spi_addr;
  logic [5:0]  spi_cmd_len;
  logic [5:0]  spi_addr_len;
  logic [15:0] spi_data_len;
  logic [15:0] spi_dummy_rd;
  logic [15:0] spi_dummy_wr;
  logic [3:0]  spi_csreg;
  logic        spi_rd;
  logic        spi_wr;
  logic        spi_qrd;
  logic        spi_qwr;
  logic        spi_swrst;
  logic [31:0] spi_data_tx;
  logic        spi_data_tx_valid;
  logic        spi_data_tx_ready;
  logic [31:0] spi_data_rx;
  logic        spi_data_rx_valid;
  logic        spi_data_rx_ready;
  logic        irq;

  spi_master_apb_regs_if #(.AW(12)) apb ();

  spi_master_apb_regs #(
    .APB_ADDR_WIDTH(12),
    .NUM_CS(4),
    .CLKDIV_W(8),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .HCLK(HCLK),
    .HRESETn(HRESETn),
    .apb(apb),
    .spi_status(spi_status),
    .spi_clk_div(spi_clk_div),
    .spi_clk_div_valid(spi_clk_div_valid),
    .spi_cmd(spi_cmd),
    .spi_addr(spi_addr),
    .spi_cmd_len(spi_cmd_len),
    .spi_addr_len(spi_addr_len),
    .spi_data_len(spi_data_len),
    .spi_dummy_rd(spi_dummy_rd),
    .spi_dummy_wr(spi_dummy_wr),
    .spi_csreg(spi_csreg),
    .spi_rd(spi_rd),
    .spi_wr(spi_wr),
    .spi_qrd(spi_qrd),
    .spi_qwr(spi_qwr),
    .spi_swrst(spi_swrst),
    .spi_data_tx(spi_data_tx),
    .spi_data_tx_valid(spi_data_tx_valid),
    .spi_data_tx_ready(spi_data_tx_ready),
    .spi_data_rx(spi_data_rx),
    .spi_data_rx_valid(spi_data_rx_valid),
    .spi_data_rx_ready(spi_data_rx_ready),
    .irq(irq)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];

  logic [31:0] r_data;
  logic        r_err;
  int          r_waits;
  int          r_pushes;
  int          r_pops;
  logic [31:0] r_push_data;
  logic [6:0]  r_p1;
  logic [6:0]  r_p2;

  wire [6:0] snap = {irq, spi_clk_div_valid, spi_swrst,
                     spi_qwr, spi_qrd, spi_wr, spi_rd};

  // rdy_after: access cycles before FIFO ready/valid rise; -1 = never
  task automatic apb_xfer(input bit w, input logic [11:0] a,
                          input logic [31:0] d, input int rdy_after);
    int  cyc;
    bit  done;
    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0;
    apb.PADDR = a; apb.PWRITE = w; apb.PWDATA = d;
    r_waits = 0; r_pushes = 0; r_pops = 0;
    r_data = '0; r_err = 1'b0; r_push_data = '0;
    done = 1'b0; cyc = 0;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    while (!done && cyc < 64) begin
      spi_data_tx_ready = (rdy_after >= 0) && (cyc >= rdy_after);
      spi_data_rx_valid = (rdy_after >= 0) && (cyc >= rdy_after);
      #1;
      if (spi_data_tx_valid && spi_data_tx_ready) begin
        r_pushes++;
        r_push_data = spi_data_tx;
      end
      if (spi_data_rx_ready) r_pops++;
      if (apb.PREADY) begin
        done = 1'b1;
        r_data = apb.PRDATA;
        r_err = apb.PSLVERR;
      end else begin
        r_waits++;
        cyc++;
        @(posedge HCLK); #1;
      end
    end
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL apb_complete addr=%h: no PREADY within 64 cycles", a);
    end
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    spi_data_tx_ready = 1'b0; spi_data_rx_valid = 1'b0;
    r_p1 = snap;
    @(posedge HCLK); #1;
    r_p2 = snap;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    HRESETn = 1'b0;
    apb.PSEL = 0; apb.PENABLE = 0; apb.PWRITE = 0;
    apb.PADDR = '0; apb.PWDATA = '0;
    spi_status = '0; spi_data_tx_ready = 0;
    spi_data_rx = '0; spi_data_rx_valid = 0;
    repeat (3) @(posedge HCLK);
    #1;
    tests++;
    if ({spi_csreg, spi_clk_div, spi_cmd, spi_addr, spi_data_len,
         snap, spi_data_tx_valid, spi_data_rx_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got csreg=%h div=%h cmd=%h snap=%b",
               spi_csreg, spi_clk_div, spi_cmd, snap);
    end
    HRESETn = 1'b1;
    spi_status = 32'h1234_5670;
    exp_q.push_back(32'h1234_5670);
    apb_xfer(1'b0, 12'h000, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e || r_err !== 1'b0) begin
      fails++;
      $display("FAIL status_read: got %h err=%b, want %h err=0",
               r_data, r_err, e);
    end
    spi_status = '0;
  endtask

  task automatic test_spilen;
    logic [31:0] e;
    apb_xfer(1'b1, 12'h014, 32'h0040_1008, -1);
    tests++;
    if (r_err !== 1'b0 || spi_data_len !== 16'h0040 ||
        spi_addr_len !== 6'd16 || spi_cmd_len !== 6'd8) begin
      fails++;
      $display("FAIL spilen_fields: err=%b dlen=%h alen=%0d clen=%0d",
               r_err, spi_data_len, spi_addr_len, spi_cmd_len);
    end
    exp_q.push_back(32'h0040_1008);
    apb_xfer(1'b0, 12'h014, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e || r_err !== 1'b0) begin
      fails++;
      $display("FAIL spilen_read: got %h err=%b, want %h", r_data, r_err, e);
    end
  endtask

  task automatic test_timeout;
    logic [31:0] e;
    apb_xfer(1'b0, 12'h020, '0, -1);
    tests++;
    if (r_waits !== 7 || r_err !== 1'b1 || r_pops !== 0 ||
        r_data !== 32'h0) begin
      fails++;
      $display("FAIL rx_timeout: waits=%0d err=%b pops=%0d, want 7 1 0",
               r_waits, r_err, r_pops);
    end
    exp_q.push_back(32'h2);
    apb_xfer(1'b0, 12'h028, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e) begin
      fails++;
      $display("FAIL tmo_pending: got %h, want %h", r_data, e);
    end
    apb_xfer(1'b1, 12'h028, 32'h3, -1);
  endtask

  task automatic test_cmd;
    spi_status = '0;
    apb_xfer(1'b1, 12'h004, 32'h0000_0202, -1);
    tests++;
    if (r_err !== 1'b0 || r_p1[4:0] !== 5'b00010 ||
        r_p2[4:0] !== 5'b0 || spi_csreg !== 4'b0010) begin
      fails++;
      $display("FAIL cmd_wr_pulse: err=%b p1=%b p2=%b cs=%b",
               r_err, r_p1[4:0], r_p2[4:0], spi_csreg);
    end
    spi_status = 32'h1;
    apb_xfer(1'b1, 12'h004, 32'h0000_0401, -1);
    tests++;
    if (r_err !== 1'b1 || r_p1[4:0] !== 5'b0 || spi_csreg !== 4'b0010) begin
      fails++;
      $display("FAIL cmd_busy_lock: err=%b p1=%b cs=%b, want 1 0 0010",
               r_err, r_p1[4:0], spi_csreg);
    end
    apb_xfer(1'b1, 12'h004, 32'h0000_0810, -1);
    tests++;
    if (r_err !== 1'b0 || r_p1[4:0] !== 5'b10000 ||
        spi_csreg !== 4'b1000) begin
      fails++;
      $display("FAIL cmd_swrst_busy: err=%b p1=%b cs=%b",
               r_err, r_p1[4:0], spi_csreg);
    end
    spi_status = '0;
  endtask

  task automatic test_clkdiv;
    logic [31:0] e;
    apb_xfer(1'b1, 12'h008, 32'h0000_0123, -1);
    tests++;
    if (spi_clk_div !== 8'h23 || r_p1[5] !== 1'b1 || r_p2[5] !== 1'b0) begin
      fails++;
      $display("FAIL clkdiv_write: div=%h v1=%b v2=%b",
               spi_clk_div, r_p1[5], r_p2[5]);
    end
    exp_q.push_back(32'h23);
    apb_xfer(1'b0, 12'h008, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e) begin
      fails++;
      $display("FAIL clkdiv_read: got %h, want %h", r_data, e);
    end
    spi_status = 32'h1;
    apb_xfer(1'b1, 12'h008, 32'h55, -1);
    tests++;
    if (r_err !== 1'b1 || spi_clk_div !== 8'h23 || r_p1[5] !== 1'b0) begin
      fails++;
      $display("FAIL clkdiv_lock: err=%b div=%h", r_err, spi_clk_div);
    end
    spi_status = '0;
  endtask

  task automatic test_errors;
    logic [31:0] e;
    exp_q.push_back(32'h0);
    apb_xfer(1'b0, 12'h030, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e || r_err !== 1'b1) begin
      fails++;
      $display("FAIL unmapped_read: got %h err=%b, want 0 err=1",
               r_data, r_err);
    end
    exp_q.push_back(32'h0);
    apb_xfer(1'b0, 12'h004, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e || r_err !== 1'b1) begin
      fails++;
      $display("FAIL cmd_read: got %h err=%b, want 0 err=1", r_data, r_err);
    end
    apb_xfer(1'b1, 12'h020, 32'h77, 0);
    tests++;
    if (r_err !== 1'b1 || r_waits !== 0 || r_pops !== 0) begin
      fails++;
      $display("FAIL rx_write: err=%b waits=%0d pops=%0d",
               r_err, r_waits, r_pops);
    end
  endtask

  task automatic test_txfifo;
    apb_xfer(1'b1, 12'h01C, 32'hA5A5_0F0F, 5);
    tests++;
    if (r_waits !== 5 || r_pushes !== 1 || r_err !== 1'b0 ||
        r_push_data !== 32'hA5A5_0F0F) begin
      fails++;
      $display("FAIL tx_wait: waits=%0d pushes=%0d err=%b data=%h",
               r_waits, r_pushes, r_err, r_push_data);
    end
  endtask

  task automatic test_rxfifo;
    logic [31:0] e;
    spi_data_rx = 32'hCAFE_F00D;
    exp_q.push_back(32'hCAFE_F00D);
    apb_xfer(1'b0, 12'h020, '0, 2);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e || r_pops !== 1 || r_waits !== 2 || r_err !== 1'b0) begin
      fails++;
      $display("FAIL rx_pop: got %h pops=%0d waits=%0d err=%b, want %h",
               r_data, r_pops, r_waits, r_err, e);
    end
  endtask

  task automatic test_irq;
    logic [31:0] e;
    apb_xfer(1'b1, 12'h028, 32'h3, -1);
    apb_xfer(1'b1, 12'h024, 32'h1, -1);
    @(posedge HCLK); #1 spi_status = 32'h1;
    @(posedge HCLK); #1 spi_status = 32'h0;
    @(posedge HCLK); #1;
    tests++;
    if (irq !== 1'b0) begin
      fails++;
      $display("FAIL irq_latency: irq=%b one edge after fall, want 0", irq);
    end
    @(posedge HCLK); #1;
    tests++;
    if (irq !== 1'b1) begin
      fails++;
      $display("FAIL irq_assert: irq=%b, want 1", irq);
    end
    exp_q.push_back(32'h1);
    apb_xfer(1'b0, 12'h028, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e) begin
      fails++;
      $display("FAIL irq_pending: got %h, want %h", r_data, e);
    end
    apb_xfer(1'b1, 12'h028, 32'h1, -1);
    tests++;
    if (r_p1[6] !== 1'b1 || r_p2[6] !== 1'b0) begin
      fails++;
      $display("FAIL irq_clear: irq after=%b,%b want 1,0", r_p1[6], r_p2[6]);
    end
  endtask

  task automatic test_irq_collide;
    logic [31:0] e;
    @(posedge HCLK); #1;
    spi_status = 32'h1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 12'h028; apb.PWDATA = 32'h1;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    spi_status = 32'h0;
    #1;
    tests++;
    if (apb.PREADY !== 1'b1 || apb.PSLVERR !== 1'b0) begin
      fails++;
      $display("FAIL collide_access: ready=%b err=%b",
               apb.PREADY, apb.PSLVERR);
    end
    @(posedge HCLK); #1;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    exp_q.push_back(32'h1);
    apb_xfer(1'b0, 12'h028, '0, -1);
    e = exp_q.pop_front();
    tests++;
    if (r_data !== e) begin
      fails++;
      $display("FAIL set_over_clear: pend=%h, want %h", r_data, e);
    end
    apb_xfer(1'b1, 12'h028, 32'h3, -1);
  endtask

  task automatic test_back_to_back;
    logic [11:0] a[5];
    logic [31:0] d[5];
    logic [31:0] x[5];
    logic [31:0] e;
    a = '{12'h00C, 12'h010, 12'h018, 12'h014, 12'h024};
    d = '{32'hDEAD_BEEF, 32'h0102_0304, 32'hBEEF_1234,
          32'hFFFF_FFFF, 32'hFFFF_FFFF};
    x = '{32'hDEAD_BEEF, 32'h0102_0304, 32'hBEEF_1234,
          32'hFFFF_3F3F, 32'h0000_0003};
    for (int i = 0; i < 5; i++) begin
      apb_xfer(1'b1, a[i], d[i], -1);
      exp_q.push_back(x[i]);
    end
    for (int i = 0; i < 5; i++) begin
      apb_xfer(1'b0, a[i], '0, -1);
      e = exp_q.pop_front();
      tests++;
      if (r_data !== e || r_err !== 1'b0) begin
        fails++;
        $display("FAIL b2b_read[%0d]: got %h err=%b, want %h",
                 i, r_data, r_err, e);
      end
    end
    tests++;
    if (spi_dummy_wr !== 16'hBEEF || spi_dummy_rd !== 16'h1234) begin
      fails++;
      $display("FAIL spidum_fields: wr=%h rd=%h", spi_dummy_wr, spi_dummy_rd);
    end
  endtask

  task automatic test_reset_mid_wait;
    int pushes;
    pushes = 0;
    @(posedge HCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = 1'b1;
    apb.PADDR = 12'h01C; apb.PWDATA = 32'h1111_2222;
    @(posedge HCLK); #1;
    apb.PENABLE = 1'b1;
    spi_data_tx_ready = 1'b0;
    repeat (3) @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #1;
    tests++;
    if ({spi_data_tx_valid, apb.PREADY, apb.PSLVERR, spi_csreg,
         spi_data_len, spi_cmd, irq} !== '0) begin
      fails++;
      $display("FAIL reset_abort: valid=%b ready=%b cs=%b dlen=%h irq=%b",
               spi_data_tx_valid, apb.PREADY, spi_csreg, spi_data_len, irq);
    end
    spi_data_tx_ready = 1'b1;
    repeat (2) begin
      @(posedge HCLK); #2;
      if (spi_data_tx_valid && spi_data_tx_ready) pushes++;
    end
    tests++;
    if (pushes !== 0) begin
      fails++;
      $display("FAIL reset_no_push: pushes=%0d, want 0", pushes);
    end
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    spi_data_tx_ready = 1'b0;
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
  endtask

  initial begin
    test_reset();
    test_spilen();
    test_timeout();
    test_cmd();
    test_clkdiv();
    test_errors();
    test_txfifo();
    test_rxfifo();
    test_irq();
    test_irq_collide();
    test_back_to_back();
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
